// File: rtl/physics_pkg.sv
// Shared definitions for the OBB impulse scheduler: field widths,
// drain FSM states, error-flag positions and the accumulator record.
package physics_pkg;

    localparam int IMP_W   = 24;
    localparam int NUDGE_W = 22;
    localparam int ROT_W   = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit positions of the sticky error flags.
    localparam int ERR_OVERRUN_BIT = 0;
    localparam int ERR_BAD_IDX_BIT = 1;
    localparam int ERR_W           = 2;

    typedef struct packed {
        logic signed [IMP_W-1:0]   imp_x;
        logic signed [IMP_W-1:0]   imp_y;
        logic signed [NUDGE_W-1:0] nudge_x;
        logic signed [NUDGE_W-1:0] nudge_y;
        logic signed [ROT_W-1:0]   rot;
    } impulse_t;

endpackage

// File: rtl/obb_impulse_scheduler_sat_add.sv
// Signed adder used for each accumulated impulse field.
// With OBB_IMPULSE_SAT_EN defined the sum clamps to the signed range of W,
// otherwise it wraps modulo 2^W.
module sat_add #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

`ifdef OBB_IMPULSE_SAT_EN
    logic signed [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};

    // Clamp when the carry-out disagrees with the sign bit.
    always_comb begin
        if (wide[W] != wide[W-1]) begin
            y = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = wide[W-1:0];
        end
    end
`else
    assign y = a + b;
`endif

endmodule

// File: rtl/obb_impulse_scheduler.sv
// Per-body collision impulse accumulator and drain scheduler.
// Records are summed per body while idle; a frame tick drains one update
// command per body through a valid/ready handshake, then pulses frame_done.
// Build option: OBB_IMPULSE_SAT_EN selects saturating accumulation.
module obb_impulse_scheduler
    import physics_pkg::*;
#(
    parameter int NUM_OBB = 4,
    parameter int IDX_W   = 4
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_tick,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IDX_W-1:0]          in_idx,
    input  logic signed [IMP_W-1:0]   in_impulse_x,
    input  logic signed [IMP_W-1:0]   in_impulse_y,
    input  logic signed [NUDGE_W-1:0] in_nudge_x,
    input  logic signed [NUDGE_W-1:0] in_nudge_y,
    input  logic signed [ROT_W-1:0]   in_rot_impulse,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      impulse_en,
    output logic                      update_en,
    output logic signed [IMP_W-1:0]   impulse_x,
    output logic signed [IMP_W-1:0]   impulse_y,
    output logic signed [NUDGE_W-1:0] nudge_x,
    output logic signed [NUDGE_W-1:0] nudge_y,
    output logic signed [ROT_W-1:0]   rotational_impulse,
    output logic                      frame_done,
    output logic                      err_overrun,
    output logic                      err_bad_idx
);

    localparam int          SEL_W    = (NUM_OBB > 1) ? $clog2(NUM_OBB) : 1;
    localparam int unsigned NUM_U    = NUM_OBB;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBB - 1);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [ERR_W-1:0]     err_flags;
    impulse_t             acc [NUM_OBB];
    logic [NUM_OBB-1:0]   hit;

    logic                 accept;
    logic                 in_range;
    logic                 handshake;
    logic [SEL_W-1:0]     in_sel;
    logic [SEL_W-1:0]     idx_sel;
    impulse_t             acc_sel;
    impulse_t             acc_sum;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign in_range  = 32'(in_idx) < NUM_U;
    assign in_sel    = in_idx[SEL_W-1:0];
    assign idx_sel   = idx[SEL_W-1:0];
    assign acc_sel   = in_range ? acc[in_sel] : '0;

    assign err_overrun = err_flags[ERR_OVERRUN_BIT];
    assign err_bad_idx = err_flags[ERR_BAD_IDX_BIT];

    sat_add #(.W(IMP_W))   u_add_imp_x   (.a(acc_sel.imp_x),   .b(in_impulse_x),   .y(acc_sum.imp_x));
    sat_add #(.W(IMP_W))   u_add_imp_y   (.a(acc_sel.imp_y),   .b(in_impulse_y),   .y(acc_sum.imp_y));
    sat_add #(.W(NUDGE_W)) u_add_nudge_x (.a(acc_sel.nudge_x), .b(in_nudge_x),     .y(acc_sum.nudge_x));
    sat_add #(.W(NUDGE_W)) u_add_nudge_y (.a(acc_sel.nudge_y), .b(in_nudge_y),     .y(acc_sum.nudge_y));
    sat_add #(.W(ROT_W))   u_add_rot     (.a(acc_sel.rot),     .b(in_rot_impulse), .y(acc_sum.rot));

    // Drain FSM: sequencing, handshake index, ready/valid/done and sticky errors.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
            err_flags  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (accept && !in_range) begin
                err_flags[ERR_BAD_IDX_BIT] <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (frame_tick) begin
                        state     <= ST_DRAIN;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (frame_tick) begin
                        err_flags[ERR_OVERRUN_BIT] <= 1'b1;
                    end
                    if (handshake) begin
                        if (idx == LAST_IDX) begin
                            state      <= ST_DONE;
                            idx        <= '0;
                            out_valid  <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (frame_tick) begin
                        err_flags[ERR_OVERRUN_BIT] <= 1'b1;
                    end
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Per-body accumulators: add accepted records, clear on drain handshake.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_U; i++) begin
                acc[i] <= '0;
            end
            hit <= '0;
        end else begin
            if (accept && in_range) begin
                acc[in_sel] <= acc_sum;
                hit[in_sel] <= 1'b1;
            end
            if (handshake) begin
                acc[idx_sel] <= '0;
                hit[idx_sel] <= 1'b0;
            end
        end
    end

    // Command outputs: the current body's accumulator while valid, else zero.
    always_comb begin
        out_idx            = idx;
        impulse_en         = 1'b0;
        update_en          = 1'b0;
        impulse_x          = '0;
        impulse_y          = '0;
        nudge_x            = '0;
        nudge_y            = '0;
        rotational_impulse = '0;
        if (out_valid) begin
            impulse_en         = hit[idx_sel];
            update_en          = 1'b1;
            impulse_x          = acc[idx_sel].imp_x;
            impulse_y          = acc[idx_sel].imp_y;
            nudge_x            = acc[idx_sel].nudge_x;
            nudge_y            = acc[idx_sel].nudge_y;
            rotational_impulse = acc[idx_sel].rot;
        end
    end

endmodule

// File: tb/tb_obb_impulse_scheduler.sv
// Testbench for obb_impulse_scheduler: directed scenarios plus randomized
// frames checked against a queue-based behavioural model.
module tb_obb_impulse_scheduler;

    localparam int N     = 4;
    localparam int IDX_W = 4;

    logic                Clk = 1'b0;
    logic                Reset_n;
    logic                frame_tick;
    logic                in_valid;
    logic                in_ready;
    logic [IDX_W-1:0]    in_idx;
    logic signed [23:0]  in_impulse_x, in_impulse_y;
    logic signed [21:0]  in_nudge_x, in_nudge_y;
    logic signed [10:0]  in_rot_impulse;
    logic                out_valid;
    logic                out_ready;
    logic [IDX_W-1:0]    out_idx;
    logic                impulse_en, update_en;
    logic signed [23:0]  impulse_x, impulse_y;
    logic signed [21:0]  nudge_x, nudge_y;
    logic signed [10:0]  rotational_impulse;
    logic                frame_done, err_overrun, err_bad_idx;

    always #5 Clk = ~Clk;

    obb_impulse_scheduler #(.NUM_OBB(N), .IDX_W(IDX_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .in_impulse_x(in_impulse_x), .in_impulse_y(in_impulse_y),
        .in_nudge_x(in_nudge_x), .in_nudge_y(in_nudge_y),
        .in_rot_impulse(in_rot_impulse),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .impulse_en(impulse_en), .update_en(update_en),
        .impulse_x(impulse_x), .impulse_y(impulse_y),
        .nudge_x(nudge_x), .nudge_y(nudge_y),
        .rotational_impulse(rotational_impulse),
        .frame_done(frame_done), .err_overrun(err_overrun), .err_bad_idx(err_bad_idx)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int     idx;
        longint f [5];
        bit     hit;
    } cmd_t;

    longint m_acc [N][5];
    bit     m_hit [N];
    bit     m_err_ov, m_err_bad;
    cmd_t   q [$];

    int     n_checks = 0;
    int     n_pass   = 0;
    bit     done_due = 0;
    bit     done_seen = 0;
    int     done_count = 0;
    int     cmd_count = 0;
    int     hs_count = 0;
    int     first_idx = -1;
    longint obs_ix [N];
    longint obs_rot [N];
    bit     obs_ien [N];
    bit     obs_uen [N];

    function automatic int fw(int k);
        case (k)
            0, 1:    return 24;
            2, 3:    return 22;
            default: return 11;
        endcase
    endfunction

    function automatic longint fit(longint v, int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        longint m  = longint'(1) << w;
`ifdef OBB_IMPULSE_SAT_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        v = v % m;
        if (v > hi) v -= m;
        if (v < lo) v += m;
        return v;
`endif
    endfunction

    function automatic void m_accept(int i, longint a, longint b, longint c, longint d, longint e);
        longint v [5];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
        if (i < N) begin
            for (int k = 0; k < 5; k++) m_acc[i][k] = fit(m_acc[i][k] + v[k], fw(k));
            m_hit[i] = 1'b1;
        end else begin
            m_err_bad = 1'b1;
        end
    endfunction

    function automatic void m_tick();
        for (int b = 0; b < N; b++) begin
            cmd_t c;
            c.idx = b;
            for (int k = 0; k < 5; k++) begin
                c.f[k] = m_acc[b][k];
                m_acc[b][k] = 0;
            end
            c.hit = m_hit[b];
            m_hit[b] = 1'b0;
            q.push_back(c);
            obs_ix[b] = -1; obs_rot[b] = -1; obs_ien[b] = 1'b0; obs_uen[b] = 1'b0;
        end
        cmd_count = 0;
        first_idx = -1;
    endfunction

    function automatic void m_reset();
        q.delete();
        for (int b = 0; b < N; b++) begin
            for (int k = 0; k < 5; k++) m_acc[b][k] = 0;
            m_hit[b] = 1'b0;
        end
        m_err_ov  = 1'b0;
        m_err_bad = 1'b0;
        done_due  = 1'b0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- compare process ----------------
    always @(negedge Clk) begin
        if (!Reset_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_errors", {err_overrun, err_bad_idx}, 0);
        end else begin
            bit busy;
            busy = (q.size() != 0) || done_due;
            chk("frame_done", frame_done, done_due);
            if (frame_done) begin
                done_seen = 1'b1;
                done_count++;
            end
            done_due = 1'b0;
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, q.size() != 0);
            chk("err_overrun", err_overrun, m_err_ov);
            chk("err_bad_idx", err_bad_idx, m_err_bad);
            if (out_valid && q.size() != 0) begin
                chk("out_idx", out_idx, q[0].idx);
                chk("impulse_x", impulse_x, q[0].f[0]);
                chk("impulse_y", impulse_y, q[0].f[1]);
                chk("nudge_x", nudge_x, q[0].f[2]);
                chk("nudge_y", nudge_y, q[0].f[3]);
                chk("rot_impulse", rotational_impulse, q[0].f[4]);
                chk("impulse_en", impulse_en, q[0].hit);
                chk("update_en", update_en, 1);
                if (out_ready) begin
                    if (cmd_count == 0) first_idx = int'(out_idx);
                    obs_ix[q[0].idx]  = impulse_x;
                    obs_rot[q[0].idx] = rotational_impulse;
                    obs_ien[q[0].idx] = impulse_en;
                    obs_uen[q[0].idx] = update_en;
                    cmd_count++;
                    hs_count++;
                    void'(q.pop_front());
                    if (q.size() == 0) done_due = 1'b1;
                end
            end else if (!out_valid) begin
                chk("idle_fields_zero",
                    |{impulse_x, impulse_y, nudge_x, nudge_y, rotational_impulse, impulse_en, update_en}, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input int i, input longint ix, input longint iy, input longint nx,
                        input longint ny, input longint rt, input bit tk);
        longint t;
        in_valid = 1'b1;
        in_idx = IDX_W'(i);
        t = ix; in_impulse_x = t[23:0];
        t = iy; in_impulse_y = t[23:0];
        t = nx; in_nudge_x = t[21:0];
        t = ny; in_nudge_y = t[21:0];
        t = rt; in_rot_impulse = t[10:0];
        frame_tick = tk;
        step();
        m_accept(i, ix, iy, nx, ny, rt);
        if (tk) m_tick();
        in_valid = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic tick_only();
        frame_tick = 1'b1;
        step();
        m_tick();
        frame_tick = 1'b0;
    endtask

    task automatic drain(input bit rnd_ready, input bit inject);
        done_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done_seen) break;
            out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            frame_tick = inject && (c == 2);
            step();
            if (frame_tick) m_err_ov = 1'b1;
            frame_tick = 1'b0;
        end
        out_ready = 1'b0;
        if (!done_seen) chk("drain_timeout", 0, 1);
    endtask

    function automatic longint rnd(int w);
        if ($urandom_range(0, 3) == 0)
            return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) << (w - 1));
        return longint'($urandom_range(0, 400)) - 200;
    endfunction

    initial begin
        int base;
        Reset_n = 1'b0; frame_tick = 1'b0; in_valid = 1'b0; in_idx = '0;
        in_impulse_x = '0; in_impulse_y = '0; in_nudge_x = '0; in_nudge_y = '0;
        in_rot_impulse = '0; out_ready = 1'b0;
        m_reset();
        repeat (3) @(negedge Clk);
        #1 Reset_n = 1'b1;
        step();

        // Two records to body 1 summed; stall the drain for five cycles.
        send(1, 100, 0, 0, 0, 0, 1'b0);
        send(1, -30, 0, 0, 0, 0, 1'b0);
        tick_only();
        for (int c = 0; c < 5; c++) begin
            chk("stall_idx", out_idx, 0);
            chk("stall_in_ready", in_ready, 0);
            step();
        end
        drain(1'b0, 1'b0);
        chk("b1_impulse_x", obs_ix[1], 70);
        chk("b1_impulse_en", obs_ien[1], 1);
        chk("b0_impulse_en", obs_ien[0], 0);
        chk("b2_impulse_en", obs_ien[2], 0);
        chk("b3_impulse_en", obs_ien[3], 0);
        chk("b3_update_en", obs_uen[3], 1);
        chk("frame1_cmds", cmd_count, 4);

        // Rotational accumulation overflow on body 0, record on the tick cycle.
        send(0, 0, 0, 0, 0, 1000, 1'b0);
        send(0, 0, 0, 0, 0, 1000, 1'b1);
        drain(1'b1, 1'b0);
`ifdef OBB_IMPULSE_SAT_EN
        chk("rot_overflow", obs_rot[0], 1023);
`else
        chk("rot_overflow", obs_rot[0], -48);
`endif

        // Out-of-range body index is discarded.
        send(7, 500, 500, 500, 500, 500, 1'b0);
        chk("bad_idx_flag", err_bad_idx, 1);
        tick_only();
        drain(1'b0, 1'b0);
        chk("bad_idx_b3_x", obs_ix[3], 0);
        chk("bad_idx_b3_en", obs_ien[3], 0);

        // Tick during drain is dropped.
        base = done_count;
        send(2, 5, 6, 7, 8, 9, 1'b1);
        drain(1'b0, 1'b1);
        repeat (5) step();
        chk("overrun_flag", err_overrun, 1);
        chk("overrun_cmds", cmd_count, 4);
        chk("overrun_done_count", done_count - base, 1);

        // Randomized frames.
        for (int fr = 0; fr < 30; fr++) begin
            int nrec;
            bit ticked;
            nrec = $urandom_range(0, 6);
            ticked = 1'b0;
            for (int r = 0; r < nrec; r++) begin
                int i;
                bit tk;
                i = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
                tk = (r == nrec - 1) && ($urandom_range(0, 1) == 1);
                send(i, rnd(24), rnd(24), rnd(22), rnd(22), rnd(11), tk);
                if (tk) ticked = 1'b1;
            end
            repeat ($urandom_range(0, 2)) step();
            if (!ticked) tick_only();
            drain(1'b1, 1'b0);
        end

        // Reset after the second drain command abandons the frame.
        send(2, 1234, 0, 0, 0, 0, 1'b0);
        send(3, 0, 0, 0, 0, 77, 1'b1);
        base = hs_count;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && hs_count < base + 2; c++) step();
        chk("pre_reset_handshakes", hs_count - base, 2);
        out_ready = 1'b0;
        Reset_n = 1'b0;
        m_reset();
        repeat (2) @(negedge Clk);
        #1 Reset_n = 1'b1;
        step();
        tick_only();
        drain(1'b0, 1'b0);
        chk("post_reset_first_idx", first_idx, 0);
        chk("post_reset_b2_x", obs_ix[2], 0);
        chk("post_reset_b2_en", obs_ien[2], 0);
        chk("post_reset_b3_rot", obs_rot[3], 0);
        chk("post_reset_cmds", cmd_count, 4);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/obb_impulse_scheduler.md
OBB_IMPULSE_SCHEDULER -- requirements
Module: obb_impulse_scheduler

Interface
REQ-001 SHALL have parameter NUM_OBB, default 4, the number of bodies served (2..16).
REQ-002 SHALL have parameter IDX_W, default 4, the body-index width.
REQ-003 SHALL have ports:
  - Clk  in  1  system clock; all state on rising edge.
  - Reset_n  in  1  asynchronous, active-low reset.
  - frame_tick  in  1  one-cycle pulse; starts one drain pass.
  - in_valid  in  1  collision record valid.
  - in_ready  out  1  scheduler accepts a record.
  - in_idx  in  IDX_W  target body.
  - in_impulse_x, in_impulse_y  in  24 signed  linear impulse.
  - in_nudge_x, in_nudge_y  in  22 signed  position correction.
  - in_rot_impulse  in  11 signed  angular impulse.
  - out_valid  out  1  per-body update command valid.
  - out_ready  in  1  updater consumed the command.
  - out_idx  out  IDX_W  body being updated.
  - impulse_en, update_en  out  1  updater enables.
  - impulse_x, impulse_y  out  24 signed  summed impulse.
  - nudge_x, nudge_y  out  22 signed  summed nudge.
  - rotational_impulse  out  11 signed  summed angular impulse.
  - frame_done  out  1  one-cycle pulse at end of drain.
  - err_overrun, err_bad_idx  out  1  sticky error flags.

Function
REQ-004 SHALL implement FSM states IDLE, DRAIN, DONE.
REQ-005 SHALL keep per-body accumulators for the five impulse fields plus a hit flag.
REQ-006 IDLE: in_ready=1, out_valid=0; on in_valid, add the record to acc[in_idx] and set hit[in_idx] in the same edge.
REQ-007 A record with in_idx>=NUM_OBB SHALL be accepted, discarded, and set err_bad_idx.
REQ-008 frame_tick in IDLE SHALL move the FSM to DRAIN with drain index 0; a record accepted on the same cycle SHALL be included in this frame.
REQ-009 DRAIN: in_ready=0; out_valid=1 starting the cycle after the tick; outputs SHALL be registered acc[idx].
REQ-010 In DRAIN, update_en SHALL be 1 for every body; impulse_en SHALL equal hit[idx].
REQ-011 Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-012 On out_valid&&out_ready, SHALL clear acc[idx] and hit[idx] and increment idx; at idx==NUM_OBB-1, SHALL go to DONE.
REQ-013 DONE SHALL assert frame_done for exactly one cycle, then return to IDLE.
REQ-014 frame_tick in DRAIN or DONE SHALL be dropped and SHALL set err_overrun.
REQ-015 Accumulation SHALL be signed and width-preserving per field (24/22/11 bits).
REQ-016 When out_valid=0, impulse fields SHALL be driven 0.

Reset
REQ-017 Reset_n low SHALL asynchronously force IDLE, idx=0, all accumulators and hit flags 0, out_valid=0, in_ready=0 while asserted, and frame_done=0 and errors=0.
REQ-018 Reset mid-DRAIN SHALL abandon the frame; no pending command SHALL survive.

Configuration
REQ-019 With OBB_IMPULSE_SAT_EN defined, every accumulation SHALL saturate to the field's signed max/min.
REQ-020 Without OBB_IMPULSE_SAT_EN, accumulation SHALL wrap modulo 2^width.

Structure
REQ-021 Field widths, the state enum, and the overrun/bad-index codes SHALL live in shared package physics_pkg.
REQ-022 One sub-module, sat_add (parameterised width, saturation controlled by the macro), SHALL be instantiated per accumulated field.

Verification
REQ-023 Two records to body 1 (impulse_x=100, then -30), then a tick -> body-1 command has impulse_x=70 and impulse_en=1; bodies 0/2/3 have impulse_en=0 and update_en=1.
REQ-024 out_ready held low for 5 cycles during DRAIN -> outputs stable, in_ready=0, no index advance.
REQ-025 Two records of rot_impulse=+1000 to body 0 -> 1023 with OBB_IMPULSE_SAT_EN defined; -48 without it.
REQ-026 A tick during DRAIN -> err_overrun=1, a single frame_done, and 4 commands only.
REQ-027 in_idx=7 with NUM_OBB=4 -> err_bad_idx=1 and no accumulator changes.
REQ-028 Reset_n asserted after the second drain command -> the next frame starts at idx 0 with all impulses 0.
